vmicro16_uart_rx: RTL and testbench
===================================

VMICRO16_UART_RX -- requirements
Module: vmicro16_uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the receive FIFO entries; it SHALL be a power of 2, between 2 and 16.
REQ-004 The block SHALL have port clk, input, width 1, meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, width 1, meaning the asynchronous active-low reset.
REQ-006 The block SHALL have port rx, input, width 1, meaning the asynchronous serial line (board RXD); it idles high.
REQ-007 The block SHALL have ports S_PADDR (input, 16), S_PWRITE (input, 1), S_PSELx (input, 1), S_PENABLE (input, 1) and S_PWDATA (input, 16), meaning the APB slave request.
REQ-008 The block SHALL have ports S_PRDATA (output, 16) and S_PREADY (output, 1), meaning the APB slave response.
REQ-009 The block SHALL have port irq, output, width 1, meaning the FIFO is not empty.

Function
REQ-010 rx SHALL pass through a two-flop synchronizer; all decoding uses the synchronized value only.
REQ-011 The receive FSM SHALL have states IDLE, START, DATA, STOP; the frame format is 8N1, LSB first.
REQ-012 IDLE->START SHALL occur on a synchronized falling edge; the bit counter is cleared.
REQ-013 In START, at CLKS_PER_BIT/2 the line is sampled: low -> DATA with the counter reset; high -> IDLE (glitch, nothing recorded).
REQ-014 In DATA, a bit SHALL be sampled every CLKS_PER_BIT cycles into a shift register; after the 8th bit -> STOP.
REQ-015 In STOP, the line SHALL be sampled after CLKS_PER_BIT cycles, then -> IDLE. High: push the byte. Low: set frame_err and discard the byte.
REQ-016 A push into a full FIFO SHALL set overrun and discard the new byte; FIFO contents are unchanged.
REQ-017 The FIFO SHALL use a synchronous circular buffer with wrapping read/write pointers and a count of width clog2(FIFO_DEPTH)+1.
REQ-018 An APB access is an access phase, S_PSELx & S_PENABLE; S_PREADY SHALL be constant 1 (zero wait states).
REQ-019 Register decode SHALL use S_PADDR[1:0].
- Addresses 2 and 3: reads return 0; writes are ignored.
REQ-020 Address 0, DATA register: a read SHALL return {8'h00, head byte} and pop exactly one entry in the access phase.
- A read while empty returns 16'h0000 with no pop and no pointer change.
- A write to DATA is ignored.
REQ-021 Address 1, STATUS register: a read SHALL return {8'h00, overrun, frame_err, full, not_empty, count[3:0]}.
- A write with S_PWDATA[7]=1 clears overrun.
- A write with S_PWDATA[6]=1 clears frame_err.
REQ-022 S_PRDATA SHALL be combinational from the current state while S_PSELx=1, and 0 otherwise.
REQ-023 A simultaneous push (from STOP) and pop in one cycle SHALL both complete; count is unchanged, even when full (no overrun in that case).
REQ-024 A simultaneous error set and software clear in one cycle: set wins.
REQ-025 irq SHALL equal not_empty, registered is not required.
REQ-026 A falling edge arriving during DATA/STOP SHALL NOT restart the frame; resync occurs only in IDLE.

Reset
REQ-027 reset low SHALL immediately and asynchronously force:
- FSM to IDLE;
- synchronizer flops to 1;
- pointers, count, overrun, frame_err to 0;
- irq to 0.
REQ-028 Reset asserted mid-frame SHALL drop the partial byte; after release the FSM waits for a fresh falling edge.
REQ-029 FIFO storage contents need not be reset.

Verification (CLK_HZ=16, BAUD=1, so CLKS_PER_BIT=16; FIFO_DEPTH=4)
REQ-030 Send 0xA5 as 8N1 -> irq=1; STATUS reads 16'h0011; DATA reads 16'h00A5; STATUS then reads 16'h0000 and irq=0.
REQ-031 Low pulse of 4 clks on rx while idle -> no push; STATUS reads 16'h0000.
REQ-032 Send 0x3C with stop bit low -> STATUS reads 16'h0040; write STATUS 16'h0040 -> STATUS reads 16'h0000.
REQ-033 Send 0x01,0x02,0x03,0x04,0x05 without reading -> STATUS reads 16'h00B4; DATA reads return 0x01..0x04 in order; a following DATA read returns 16'h0000.
REQ-034 Assert reset during bit 3 of a frame, release, then send 0x7E -> only 0x7E is in the FIFO (count=1).
REQ-035 FIFO full, and a DATA read lands in the same cycle as the next stop-bit push -> count stays 4; overrun stays 0; byte order is preserved.

Source files
------------

// File: rtl/vmicro16_uart_rx.sv
// vmicro16_uart_rx: 8N1 UART receiver with a receive FIFO behind an APB slave
module vmicro16_uart_rx #(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   input  logic [15:0] S_PADDR,
   input  logic        S_PWRITE,
   input  logic        S_PSELx,
   input  logic        S_PENABLE,
   input  logic [15:0] S_PWDATA,
   output logic [15:0] S_PRDATA,
   output logic        S_PREADY,
   output logic        irq
);
   localparam int CPB  = CLK_HZ / BAUD;
   localparam int HALF = (CPB / 2 > 0) ? CPB / 2 : 1;
   localparam int CW   = $clog2(CPB + 1);
   localparam int AW   = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t          state_q;
   logic [1:0]      sync_q;
   logic            prev_q;
   logic [CW-1:0]   clk_cnt_q;
   logic [2:0]      bit_cnt_q;
   logic [7:0]      shift_q;
   logic            push_q;
   logic            ferr_set_q;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wp_q;
   logic [AW-1:0]   rp_q;
   logic [AW:0]     cnt_q;
   logic [AW:0]     cnt_d;
   logic            overrun_q;
   logic            overrun_d;
   logic            frame_err_q;
   logic            frame_err_d;
   logic            rx_s;
   logic            fall;
   logic            bit_tick;
   logic            acc;
   logic            full;
   logic            not_empty;
   logic            pop;
   logic            push_ok;
   logic            clr;
   logic [4:0]      cnt5;
   logic            unused_ok;
   assign rx_s      = sync_q[1];
   assign fall      = prev_q & ~rx_s;
   assign bit_tick  = clk_cnt_q == CW'(CPB - 1);
   assign acc       = S_PSELx & S_PENABLE;
   assign full      = cnt_q == (AW+1)'(FIFO_DEPTH);
   assign not_empty = cnt_q != '0;
   assign pop       = acc & ~S_PWRITE & (S_PADDR[1:0] == 2'd0) & not_empty;
   assign push_ok   = push_q & (~full | pop);
   assign clr       = acc & S_PWRITE & (S_PADDR[1:0] == 2'd1);
   assign cnt5      = 5'(cnt_q);
   assign S_PREADY  = 1'b1;
   assign irq       = not_empty;
   assign unused_ok = ^{S_PADDR[15:2], S_PWDATA[15:8], S_PWDATA[5:0], cnt5[4]};
   // two-flop synchronizer plus a delayed copy for falling-edge detection
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], rx};
         prev_q <= sync_q[1];
      end
   // receive FSM: mid-bit sampling, emits one-cycle push or framing-error pulses
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q    <= IDLE;
         clk_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         push_q     <= 1'b0;
         ferr_set_q <= 1'b0;
      end else begin
         push_q     <= 1'b0;
         ferr_set_q <= 1'b0;
         case (state_q)
            IDLE:
               if (fall) begin
                  state_q   <= START;
                  clk_cnt_q <= '0;
                  bit_cnt_q <= '0;
               end
            START:
               if (clk_cnt_q == CW'(HALF - 1)) begin
                  state_q   <= rx_s ? IDLE : DATA;
                  clk_cnt_q <= '0;
               end else clk_cnt_q <= clk_cnt_q + CW'(1);
            DATA:
               if (bit_tick) begin
                  shift_q   <= {rx_s, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  clk_cnt_q <= '0;
                  if (bit_cnt_q == 3'd7) state_q <= STOP;
               end else clk_cnt_q <= clk_cnt_q + CW'(1);
            STOP:
               if (bit_tick) begin
                  state_q    <= IDLE;
                  push_q     <= rx_s;
                  ferr_set_q <= ~rx_s;
                  clk_cnt_q  <= '0;
               end else clk_cnt_q <= clk_cnt_q + CW'(1);
            default: state_q <= IDLE;
         endcase
      end
   // next occupancy and sticky flags; a new error outranks a software clear
   always_comb begin
      cnt_d       = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
      overrun_d   = (push_q & full & ~pop) | (overrun_q & ~(clr & S_PWDATA[7]));
      frame_err_d = ferr_set_q | (frame_err_q & ~(clr & S_PWDATA[6]));
   end
   // FIFO pointers, occupancy and sticky error flags
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wp_q        <= '0;
         rp_q        <= '0;
         cnt_q       <= '0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if (push_ok) wp_q <= wp_q + AW'(1);
         if (pop) rp_q <= rp_q + AW'(1);
         cnt_q       <= cnt_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   // FIFO storage, deliberately not reset
   always_ff @(posedge clk)
      if (push_ok) mem_q[wp_q] <= shift_q;
   // APB read mux, driven only while selected
   always_comb
      S_PRDATA = !S_PSELx ? 16'h0000 :
                 S_PADDR[1:0] == 2'd0 ? {8'h00, not_empty ? mem_q[rp_q] : 8'h00} :
                 S_PADDR[1:0] == 2'd1 ? {8'h00, overrun_q, frame_err_q, full, not_empty, cnt5[3:0]} :
                 16'h0000;
endmodule

// File: tb/tb_vmicro16_uart_rx.sv
// tb_vmicro16_uart_rx: randomized scoreboard bench for the UART receiver
module tb_vmicro16_uart_rx;
   localparam int DEPTH = 4;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx = 1'b1;
   logic [15:0] paddr = '0;
   logic [15:0] pwdata = '0;
   logic        pwrite = 1'b0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic [15:0] prdata;
   logic        pready;
   logic        irq;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   logic [7:0]  model_fifo[$];
   logic        m_ovr = 1'b0;
   logic        m_ferr = 1'b0;

   vmicro16_uart_rx #(.CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .rx(rx),
      .S_PADDR(paddr), .S_PWRITE(pwrite), .S_PSELx(psel), .S_PENABLE(penable), .S_PWDATA(pwdata),
      .S_PRDATA(prdata), .S_PREADY(pready), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] m_status();
      int n = model_fifo.size();
      return {8'h00, m_ovr, m_ferr, n == DEPTH, n != 0, 4'(n)};
   endfunction

   // monitor: every APB read access phase is compared against the oldest expectation
   always @(negedge clk)
      if (psel && penable && !pwrite) begin
         check("pready", {15'd0, pready}, 16'h0001);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: got %h expected no read", prdata);
         end else check("apb_read", prdata, exp_q.pop_front());
      end

   task automatic apb_read(input logic [1:0] a);
      logic [15:0] e;
      e = 16'h0000;
      if (a == 2'd0 && model_fifo.size() != 0) e = {8'h00, model_fifo.pop_front()};
      else if (a == 2'd1) e = m_status();
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {14'($urandom), a};
      @(posedge clk); #1;
      penable = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic apb_write(input logic [1:0] a, input logic [15:0] d);
      if (a == 2'd1) begin
         if (d[7]) m_ovr = 1'b0;
         if (d[6]) m_ferr = 1'b0;
      end
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {14'($urandom), a}; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_ok);
      @(posedge clk); #1 rx = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (16) @(posedge clk);
         #1 rx = b[i];
      end
      repeat (16) @(posedge clk);
      #1 rx = stop_ok;
      repeat (16) @(posedge clk);
      #1 rx = 1'b1;
      if (!stop_ok) m_ferr = 1'b1;
      else if (model_fifo.size() < DEPTH) model_fifo.push_back(b);
      else m_ovr = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic check_irq();
      check("irq", {15'd0, irq}, {15'd0, model_fifo.size() != 0});
   endtask

   initial begin
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_irq();
      apb_read(2'd1);
      @(negedge clk) reset = 1'b1;
      // single good frame
      send_frame(8'hA5, 1'b1);
      check_irq();
      psel = 1'b0; paddr = 16'h0001;
      #1 check("prdata_unselected", prdata, 16'h0000);
      apb_read(2'd1);
      apb_read(2'd0);
      apb_read(2'd1);
      check_irq();
      // short low glitch while idle
      @(posedge clk); #1 rx = 1'b0;
      repeat (4) @(posedge clk);
      #1 rx = 1'b1;
      repeat (40) @(posedge clk);
      apb_read(2'd1);
      // framing error then software clear
      send_frame(8'h3C, 1'b0);
      apb_read(2'd1);
      apb_read(2'd0);
      apb_write(2'd1, 16'h0040);
      apb_read(2'd1);
      // overrun with a four-entry FIFO
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      apb_read(2'd1);
      for (int i = 0; i < 5; i++) apb_read(2'd0);
      apb_write(2'd1, 16'h0080);
      apb_read(2'd1);
      check_irq();
      // reset in the middle of a frame drops the partial byte and the FIFO
      send_frame(8'h11, 1'b1);
      check_irq();
      @(posedge clk); #1 rx = 1'b0;
      repeat (16) @(posedge clk);
      #1 rx = 1'b1;
      repeat (56) @(posedge clk);
      #1 reset = 1'b0;
      model_fifo.delete();
      m_ovr = 1'b0;
      m_ferr = 1'b0;
      #1 check_irq();
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (40) @(posedge clk);
      send_frame(8'h7E, 1'b1);
      apb_read(2'd1);
      apb_read(2'd0);
      // full FIFO: a pop in the same cycle as the next push
      for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1);
      apb_read(2'd1);
      fork
         send_frame(8'($urandom), 1'b1);
         begin
            @(posedge clk);
            repeat (153) @(posedge clk);
            apb_read(2'd0);
         end
      join
      apb_read(2'd1);
      for (int i = 0; i < DEPTH; i++) apb_read(2'd0);
      apb_read(2'd1);
      // randomized mix of frames and register traffic
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 5))
            0, 1: send_frame(8'($urandom), $urandom_range(0, 7) != 0);
            2: apb_read(2'd0);
            3: apb_read(2'd1);
            4: apb_write(2'($urandom_range(0, 3)), 16'($urandom));
            default: apb_read(2'($urandom_range(2, 3)));
         endcase
         check_irq();
      end
      apb_read(2'd1);
      repeat (5) @(posedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL pending_reads: got %0d outstanding expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
